// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive/transmit pair.
// Contents: receiver state encoding, bit-period width, default baud divisor,
// default payload width.
package uart_pkg;

    localparam int unsigned BR_WIDTH          = 15;
    localparam int unsigned BR_115200_100MHZ  = 868;
    localparam int unsigned DATA_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset; all stages reset to 1 (idle-high line)
//   d     - asynchronous input
//   q     - synchronized output
// STAGES must be at least 2.
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift chain: d enters at bit 0, q leaves from the top stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with runtime bit period.
// Ports:
//   clk           - system clock, rising edge
//   Reset         - synchronous active-high reset
//   BR_Clocks     - clocks per bit (4..32767), captured at start detect
//   Enable        - receiver enable, only looked at while idle
//   Rx_Serial     - asynchronous serial line, idle high
//   Rx_Parallel   - last good byte, held until the next good frame
//   Rx_Valid      - one-cycle strobe when Rx_Parallel updates
//   Rx_Busy       - high from start detect until back in IDLE
//   Framing_Error - one-cycle strobe when the stop bit samples low
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DATA_BITS_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [BR_WIDTH-1:0]  BR_Clocks,
    input  logic                 Enable,
    input  logic                 Rx_Serial,
    output logic [DATA_BITS-1:0] Rx_Parallel,
    output logic                 Rx_Valid,
    output logic                 Rx_Busy,
    output logic                 Framing_Error
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 rx_s;
    rx_state_t            state, state_next;
    logic [BR_WIDTH-1:0]  cnt, cnt_next;
    logic [BR_WIDTH-1:0]  br, br_next;
    logic [IDX_W-1:0]     bit_idx, idx_next;
    logic [DATA_BITS-1:0] shreg, sh_next;
    logic [DATA_BITS-1:0] par_next;
    logic                 valid_next, busy_next, ferr_next;
    logic [BR_WIDTH-1:0]  half_m1, full_m1;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (Reset),
        .d     (Rx_Serial),
        .q     (rx_s)
    );

    // Sample points: mid start bit, then one full period per later bit.
    assign half_m1 = (br >> 1) - BR_WIDTH'(1);
    assign full_m1 = br - BR_WIDTH'(1);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state         <= IDLE;
            cnt           <= '0;
            br            <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            Rx_Parallel   <= '0;
            Rx_Valid      <= 1'b0;
            Rx_Busy       <= 1'b0;
            Framing_Error <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            br            <= br_next;
            bit_idx       <= idx_next;
            shreg         <= sh_next;
            Rx_Parallel   <= par_next;
            Rx_Valid      <= valid_next;
            Rx_Busy       <= busy_next;
            Framing_Error <= ferr_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + BR_WIDTH'(1);
        br_next    = br;
        idx_next   = bit_idx;
        sh_next    = shreg;
        par_next   = Rx_Parallel;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (Enable && !rx_s) begin
                    br_next    = BR_Clocks;
                    state_next = START;
                end
            end
            START: begin
                if (cnt == half_m1) begin
                    cnt_next = '0;
                    idx_next = '0;
                    // A line that is high again at mid start bit was a glitch.
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == full_m1) begin
                    cnt_next = '0;
                    sh_next  = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        state_next = STOP;
                    end else begin
                        idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (cnt == full_m1) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        par_next   = shreg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold here so a stuck-low line reports only one error.
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. A behavioural serial driver
// pushes the expected byte/error per frame; a negedge monitor checks strobes.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned DB = 8;
    localparam int unsigned SS = 2;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic [14:0]   BR_Clocks = 15'd16;
    logic          Enable = 1'b1;
    logic          Rx_Serial = 1'b1;
    logic [DB-1:0] Rx_Parallel;
    logic          Rx_Valid;
    logic          Rx_Busy;
    logic          Framing_Error;

    uart_rx #(
        .DATA_BITS   (DB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .BR_Clocks     (BR_Clocks),
        .Enable        (Enable),
        .Rx_Serial     (Rx_Serial),
        .Rx_Parallel   (Rx_Parallel),
        .Rx_Valid      (Rx_Valid),
        .Rx_Busy       (Rx_Busy),
        .Framing_Error (Framing_Error)
    );

    always #5 clk = ~clk;

    longint cycle = 0;
    always @(posedge clk) cycle++;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        longint     exp_cycle;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] last_good = 8'h00;
    bit         busy_seen = 1'b0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cycle);
        end
    endtask

    // Monitor: pop one expectation per strobe.
    always @(negedge clk) begin : monitor
        exp_t   e;
        longint d;
        if (Rx_Busy) busy_seen = 1'b1;
        if (Rx_Valid || Framing_Error) begin
            check(!(Rx_Valid && Framing_Error), "strobe_exclusive",
                  longint'({Rx_Valid, Framing_Error}), 0);
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_strobe", longint'({Rx_Valid, Framing_Error}), 0);
            end else begin
                e = sb.pop_front();
                if (e.is_err) begin
                    check(Framing_Error, "ferr_kind", longint'(Framing_Error), 1);
                    check(Rx_Parallel == last_good, "ferr_hold_data",
                          longint'(Rx_Parallel), longint'(last_good));
                end else begin
                    check(Rx_Valid, "valid_kind", longint'(Rx_Valid), 1);
                    check(Rx_Parallel == e.data, "rx_data",
                          longint'(Rx_Parallel), longint'(e.data));
                    last_good = e.data;
                end
                if (e.exp_cycle >= 0) begin
                    d = cycle - e.exp_cycle;
                    if (d < 0) d = -d;
                    check(d <= longint'(SS + 1), "latency", cycle, e.exp_cycle);
                end
            end
        end
    end

    // Drive one 8N1 frame at br clocks/bit; entry must be at a negedge.
    task automatic send_frame(input logic [7:0] d, input int br, input bit stop,
                              input bit expect_it, input bit check_lat);
        exp_t e;
        if (expect_it) begin
            e.is_err    = !stop;
            e.data      = d;
            // Pin edge to detect, then half bit, nine full bits, one register stage.
            e.exp_cycle = check_lat ? cycle + longint'(SS + 1) + longint'(br / 2)
                                      + longint'((DB + 1) * br) + 1 : -1;
            sb.push_back(e);
        end
        Rx_Serial = 1'b0;
        repeat (br) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            Rx_Serial = d[i];
            repeat (br) @(negedge clk);
        end
        Rx_Serial = stop;
        repeat (br) @(negedge clk);
    endtask

    task automatic idle(input int n);
        Rx_Serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(Rx_Parallel == 8'h00, {tag, "_parallel"}, longint'(Rx_Parallel), 0);
        check(!Rx_Valid, {tag, "_valid"}, longint'(Rx_Valid), 0);
        check(!Rx_Busy, {tag, "_busy"}, longint'(Rx_Busy), 0);
        check(!Framing_Error, {tag, "_ferr"}, longint'(Framing_Error), 0);
    endtask

    initial begin : stim
        int         rbr;
        logic [7:0] rd;
        int         w;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        Reset = 1'b0;
        idle(20);

        // Loopback-style frame at 115200 baud divisor with latency check.
        BR_Clocks = 15'(BR_115200_100MHZ);
        send_frame(8'hAA, int'(BR_115200_100MHZ), 1'b1, 1'b1, 1'b1);
        idle(40);

        // Fast rate, back-to-back frames.
        BR_Clocks = 15'd16;
        send_frame(8'h55, 16, 1'b1, 1'b1, 1'b1);
        send_frame(8'h0F, 16, 1'b1, 1'b1, 1'b1);
        idle(64);

        // Three-clock glitch: busy blips, no strobe.
        busy_seen = 1'b0;
        Rx_Serial = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        check(busy_seen, "glitch_busy_seen", longint'(busy_seen), 1);
        check(!Rx_Busy, "glitch_back_idle", longint'(Rx_Busy), 0);

        // Framing error with line held low, then a good frame.
        send_frame(8'h3C, 16, 1'b0, 1'b1, 1'b0);
        repeat (48) @(negedge clk);
        idle(32);
        check(!Rx_Busy, "break_released", longint'(Rx_Busy), 0);
        send_frame(8'h81, 16, 1'b1, 1'b1, 1'b0);
        idle(64);

        // Reset during data bit 4 of 0xFF.
        fork
            send_frame(8'hFF, 16, 1'b1, 1'b0, 1'b0);
            begin
                repeat (16 * 5 + 8) @(negedge clk);
                Reset = 1'b1;
                @(negedge clk);
                Reset = 1'b0;
                check_reset_outputs("midframe_reset");
                last_good = 8'h00;
            end
        join
        idle(32);
        check(!Rx_Busy, "after_reset_idle", longint'(Rx_Busy), 0);
        send_frame(8'h12, 16, 1'b1, 1'b1, 1'b0);
        idle(64);

        // Divisor change mid-frame must not disturb the current frame.
        BR_Clocks = 15'(BR_115200_100MHZ);
        fork
            send_frame(8'hC3, int'(BR_115200_100MHZ), 1'b1, 1'b1, 1'b1);
            begin
                repeat (int'(BR_115200_100MHZ) * 3) @(negedge clk);
                BR_Clocks = 15'd16;
            end
        join
        idle(40);
        send_frame(8'h6B, 16, 1'b1, 1'b1, 1'b1);
        idle(64);

        // Disabled receiver ignores a frame; mid-frame disable is ignored.
        Enable = 1'b0;
        send_frame(8'h5A, 16, 1'b1, 1'b0, 1'b0);
        idle(32);
        Enable = 1'b1;
        idle(8);
        fork
            send_frame(8'hE7, 16, 1'b1, 1'b1, 1'b0);
            begin
                repeat (40) @(negedge clk);
                Enable = 1'b0;
            end
        join
        Enable = 1'b1;
        idle(32);

        // Randomized frames at random rates and gaps.
        for (int k = 0; k < 12; k++) begin
            rbr = int'($urandom_range(16, 64));
            rd  = 8'($urandom);
            BR_Clocks = 15'(rbr);
            send_frame(rd, rbr, 1'b1, 1'b1, 1'b1);
            idle(int'($urandom_range(0, 2)) * rbr);
        end
        idle(16);

        w = 0;
        while (sb.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check(sb.size() == 0, "scoreboard_drain", longint'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cycle);
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART link, paired with the existing `UART_Tx` transmitter. It deserialises an asynchronous 8N1 stream (idle-high, start bit, 8 data bits LSB first, 1 stop bit) into a parallel byte. The bit period is set at runtime by the same `BR_Clocks` value used by the transmitter, e.g. 868 clocks per bit for 115200 baud at 100 MHz. It sits between the board RX pin and the byte consumer, and presents each received byte with a single-cycle valid strobe.

## Interface
Parameters:
- `DATA_BITS`, 8: payload bits per frame.
- `SYNC_STAGES`, 2: synchronizer depth on `Rx_Serial`; must be ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `BR_Clocks`  in  15  clocks per bit; legal range 4..32767. Captured at start detect and held for the whole frame.
- `Enable`  in  1  receiver enable; sampled only in IDLE.
- `Rx_Serial`  in  1  asynchronous serial line, idle high.
- `Rx_Parallel`  out  DATA_BITS  last good byte; holds until the next good frame.
- `Rx_Valid`  out  1  one-cycle pulse when `Rx_Parallel` is updated.
- `Rx_Busy`  out  1  high from start detect until return to IDLE.
- `Framing_Error`  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- `Rx_Serial` passes through the SYNC_STAGES flop chain. All logic uses the synchronized bit `rx_s`. Synchronizer flops reset to 1.
- A 15-bit counter `cnt` runs against the captured `br`. A 3-bit index `bit_idx` counts data bits. A shift register fills LSB first, shifting right so that bit 0 arrives first.
- States:
  - IDLE: `Rx_Busy`=0. If `Enable`=1 and `rx_s`=0, capture `br`←`BR_Clocks`, set `cnt`←0, go to START.
  - START: when `cnt`==(`br`>>1)−1, sample `rx_s`. If 0, set `cnt`←0 and go to DATA. If 1, this is a false start: go to IDLE with no strobe.
  - DATA: when `cnt`==`br`−1, shift in `rx_s` and set `cnt`←0. After the DATA_BITS-th sample, go to STOP.
  - STOP: when `cnt`==`br`−1, sample `rx_s`. If 1, load `Rx_Parallel` and pulse `Rx_Valid`, then go to IDLE. If 0, pulse `Framing_Error` without updating `Rx_Parallel`, then go to BREAK.
  - BREAK: wait until `rx_s`=1, then go to IDLE. A held-low line therefore produces exactly one error pulse.
- `Rx_Valid` and `Framing_Error` are never high together.
- Changes to `BR_Clocks` or `Enable` mid-frame have no effect on the current frame.
- `Reset` wins over all other activity. Mid-frame it aborts the frame with no strobe.

## Timing
- Reset values: `Rx_Parallel`=0, `Rx_Valid`=0, `Rx_Busy`=0, `Framing_Error`=0, state IDLE, counters 0.
- Start detect occurs SYNC_STAGES+1 clocks after the falling edge at the pin. `Rx_Busy` rises on the clock after detect.
- Samples land at mid-bit: the start bit at `br`/2 clocks after detect, and each later bit `br` clocks after the previous sample.
- `Rx_Valid` or `Framing_Error` is registered and asserts on the clock after the stop sample. `Rx_Busy` falls in that same cycle.
- Detect-to-strobe latency is (`br`>>1) + (DATA_BITS+1)·`br` + 1 clocks.
- Back-to-back frames: the next start is detected as soon as the state is IDLE and `rx_s`=0. No idle bit is required, because the stop sample is at mid-bit.
- Per-frame tolerance: about ±4% total clock mismatch at `br` ≥ 16.

## Structure
- Shared package `uart_pkg`:
  - state enum `rx_state_t` (IDLE, START, DATA, STOP, BREAK);
  - `BR_WIDTH`=15;
  - `BR_115200_100MHZ`=868;
  - `DATA_BITS_DEFAULT`=8.
- Sub-module `uart_sync`: parameterised N-flop synchronizer with reset value 1. It is reusable for other async inputs.

## Test plan
1. Loopback: `UART_Tx` at `BR_Clocks`=868 sends 0xAA into `uart_rx`. Required: exactly one `Rx_Valid`, `Rx_Parallel`=0xAA, at the latency above ±(SYNC_STAGES+1) clocks; `Framing_Error` stays 0.
2. Fast rate: `BR_Clocks`=16, driven stream 0x55 followed immediately by 0x0F with no idle gap. Required: two `Rx_Valid` pulses, 0x55 then 0x0F.
3. Glitch: line low for 3 clocks at `BR_Clocks`=16. Required: `Rx_Busy` pulses high and then returns to IDLE; no `Rx_Valid` and no `Framing_Error`.
4. Framing error: send 0x3C with the stop bit forced to 0, hold the line low 3 bit times, then release. Required: one `Framing_Error` pulse; `Rx_Parallel` keeps its old value; after release, a following 0x81 frame is received correctly.
5. Reset mid-frame: assert `Reset` for 1 clock during data bit 4 of 0xFF. Required: all outputs at reset values; no strobe; the next frame 0x12 is received correctly.
6. Rate change mid-frame: change `BR_Clocks` from 868 to 16 during the DATA state. Required: the current byte is decoded at 868; the next frame at 16 is decoded correctly.
